apb_rr_master: RTL and testbench

- APB3 master that shares one APB slave port (8-bit data, 16-entry register/memory slave) between NREQ local requesters.
- Round-robin arbitration, simple valid/ready request handshake, one-cycle response pulse per requester.
- Drives the full SETUP/ACCESS sequence and bounds every ACCESS phase with a timeout so a stuck slave cannot hang the bus.

---
 rtl/apb_rr_pkg.sv | 29 ++
 rtl/apb_rr_arbiter.sv | 42 ++++
 rtl/apb_rr_master.sv | 154 +++++++++++++++
 tb/tb_apb_rr_master.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_rr_pkg.sv
// apb_rr_pkg
//   Shared definitions for the round-robin APB3 master:
//   - state_e     : bus sequencer state (IDLE / SETUP / ACCESS)
//   - *_DEF       : default parameter values
//   - cnt_width() : width of the ACCESS-phase timeout counter
//   - idx_width() : width of a requester index
package apb_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam int NREQ_DEF    = 2;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

  // Counter must hold 0..TIMEOUT-1.
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter
//   Combinational round-robin pick. The search starts one position after
//   the last granted requester and wraps, so the most recent winner has
//   the lowest priority.
//   Ports:
//     req_valid_i  : per-requester request vector
//     last_grant_i : index of the previous winner
//     grant_oh_o   : one-hot grant (all zero when nothing requests)
//     grant_idx_o  : index of the granted requester
//     grant_vld_o  : at least one requester is valid
module apb_rr_arbiter
  import apb_rr_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req_valid_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [NREQ-1:0]  grant_oh_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  always_comb begin
    int  idx;
    logic found;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_i) + k) % NREQ;
      if (!found && req_valid_i[idx]) begin
        found           = 1'b1;
        grant_oh_o[idx] = 1'b1;
        grant_idx_o     = IDX_W'(idx);
      end
    end
    grant_vld_o = found;
  end

endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master
//   APB3 master shared by NREQ local requesters. Requests are accepted one
//   at a time in IDLE with round-robin fairness, run through SETUP/ACCESS,
//   and completed with a one-cycle rsp_valid pulse to the owner. ACCESS is
//   bounded by TIMEOUT cycles; an expired access completes with an error.
//   Ports:
//     pclk, preset                    : clock, synchronous active-high reset
//     req_valid/ready/addr/wdata/write: requester handshake (flat-packed)
//     rsp_valid/rdata/err             : completion pulse and result
//     paddr/psel/penable/pwrite/pwdata: APB request side
//     prdata/pready/pslverr           : APB response side
//     busy, timeout_evt               : status
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ-1:0]          req_write,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDR_W-1:0]        paddr,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [DATA_W-1:0]        pwdata,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pready,
  input  logic                     pslverr,
  output logic                     busy,
  output logic                     timeout_evt
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NREQ-1:0]  ONE_OH   = NREQ'(1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               write_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NREQ-1:0]    rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;
  logic               tmo_q;

  logic [NREQ-1:0]    grant_oh;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic               accept;
  logic               tmo_hit;

  apb_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_q),
    .grant_oh_o   (grant_oh),
    .grant_idx_o  (grant_idx),
    .grant_vld_o  (grant_vld)
  );

  assign accept  = (state_q == ST_IDLE) && grant_vld;
  assign tmo_hit = (state_q == ST_ACCESS) && !pready && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge pclk) begin
    if (preset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_vld) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready || (cnt_q == CNT_LAST)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready only offered while IDLE
  always_comb begin
    psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    penable   = (state_q == ST_ACCESS);
    busy      = (state_q != ST_IDLE);
    req_ready = (state_q == ST_IDLE) ? grant_oh : '0;
  end

  // Capture, timeout counter and response registers. last_q doubles as
  // the owner of the in-flight transfer. Reset points it at NREQ-1 so
  // requester 0 is searched first.
  always_ff @(posedge pclk) begin
    if (preset) begin
      last_q      <= IDX_W'(NREQ - 1);
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      tmo_q       <= 1'b0;
      if (accept) begin
        last_q  <= grant_idx;
        addr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[grant_idx*DATA_W +: DATA_W];
        write_q <= req_write[grant_idx];
      end
      if (state_q == ST_ACCESS) begin
        if (pready) begin
          cnt_q       <= '0;
          rsp_valid_q <= ONE_OH << last_q;
          rsp_err_q   <= pslverr;
          rsp_rdata_q <= (!write_q && !pslverr) ? prdata : '0;
        end else if (tmo_hit) begin
          cnt_q       <= '0;
          rsp_valid_q <= ONE_OH << last_q;
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
          tmo_q       <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign paddr       = addr_q;
  assign pwdata      = wdata_q;
  assign pwrite      = write_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign timeout_evt = tmo_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master
//   Directed bench for apb_rr_master with a 16-entry APB slave model.
//   Addresses >= 16 answer with pslverr; 'stall' holds pready low.
module tb_apb_rr_master;

  localparam int NREQ    = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic                   pclk = 1'b0;
  logic                   preset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_write;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic [ADDR_W-1:0]      paddr;
  logic                   psel, penable, pwrite;
  logic [DATA_W-1:0]      pwdata;
  logic [DATA_W-1:0]      prdata;
  logic                   pready, pslverr;
  logic                   busy, timeout_evt;

  logic                   stall;
  logic [7:0]             mem [16];

  int errors = 0;
  int checks = 0;

  apb_rr_master #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .timeout_evt(timeout_evt)
  );

  always #5 pclk = ~pclk;

  // Slave model
  assign pready  = !stall;
  assign pslverr = psel && penable && (paddr >= 32'd16);
  assign prdata  = (paddr < 32'd16) ? mem[paddr[3:0]] : 8'hEE;

  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite && (paddr < 32'd16))
      mem[paddr[3:0]] <= pwdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [7:0] d, input logic w);
    req_valid[i]               = v;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_write[i]               = w;
  endtask

  // Issue one transfer from requester i; returns at the response cycle.
  task automatic xfer(input int i, input logic [31:0] a, input logic [7:0] d,
                      input logic w, input logic [1:0] exp_rdy);
    set_req(i, 1'b1, a, d, w);
    #1 chk("xfer_ready", 32'(req_ready), 32'(exp_rdy));
    step();
    set_req(i, 1'b0, 32'h0, 8'h0, 1'b0);
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
    stall     = 1'b0;
    preset    = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = '0;
    step();
    step();
    // Reset state
    chk("rst_psel",    32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_rspv",    32'(rsp_valid), 32'd0);
    chk("rst_paddr",   paddr, 32'd0);
    chk("rst_pwdata",  32'(pwdata), 32'd0);
    chk("rst_rdata",   32'(rsp_rdata), 32'd0);
    chk("rst_err",     32'(rsp_err), 32'd0);
    chk("rst_tmo",     32'(timeout_evt), 32'd0);
    preset = 1'b0;
    step();

    // Write 0xA5 to addr 3 from req0, cycle-by-cycle
    set_req(0, 1'b1, 32'd3, 8'hA5, 1'b1);
    #1 chk("w_ready", 32'(req_ready), 32'd1);
    step();
    set_req(0, 1'b0, 32'd0, 8'h0, 1'b0);
    chk("w_setup_psel", 32'(psel), 32'd1);
    chk("w_setup_pen",  32'(penable), 32'd0);
    chk("w_paddr",      paddr, 32'd3);
    chk("w_pwrite",     32'(pwrite), 32'd1);
    chk("w_pwdata",     32'(pwdata), 32'hA5);
    chk("w_busy",       32'(busy), 32'd1);
    step();
    chk("w_access_pen", 32'(penable), 32'd1);
    chk("w_access_psel", 32'(psel), 32'd1);
    step();
    chk("w_rspv",  32'(rsp_valid), 32'd1);
    chk("w_err",   32'(rsp_err), 32'd0);
    chk("w_psel0", 32'(psel), 32'd0);
    step();
    chk("w_rspv_drop", 32'(rsp_valid), 32'd0);

    // Read addr 3 from req1
    xfer(1, 32'd3, 8'h00, 1'b0, 2'b10);
    chk("r_rspv",  32'(rsp_valid), 32'd2);
    chk("r_rdata", 32'(rsp_rdata), 32'hA5);
    chk("r_err",   32'(rsp_err), 32'd0);

    // Both requesters held valid: grants 0,1,0,1 back to back
    set_req(0, 1'b1, 32'd5, 8'h11, 1'b1);
    set_req(1, 1'b1, 32'd6, 8'h22, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_ready", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) chk("rr_rspv", 32'(rsp_valid), (i % 2 == 1) ? 32'd1 : 32'd2);
      step();
      if (i == 3) begin
        set_req(0, 1'b0, 32'd0, 8'h0, 1'b0);
        set_req(1, 1'b0, 32'd0, 8'h0, 1'b0);
      end
      step();
      step();
    end
    chk("rr_rspv_last", 32'(rsp_valid), 32'd2);

    // Out-of-range read -> slave error, rdata forced to zero
    xfer(0, 32'd20, 8'h00, 1'b0, 2'b01);
    chk("oor_rspv",  32'(rsp_valid), 32'd1);
    chk("oor_err",   32'(rsp_err), 32'd1);
    chk("oor_rdata", 32'(rsp_rdata), 32'd0);

    // Read back what req1 wrote during the round-robin run
    xfer(1, 32'd6, 8'h00, 1'b0, 2'b10);
    chk("rb_rdata", 32'(rsp_rdata), 32'h22);
    chk("rb_rspv",  32'(rsp_valid), 32'd2);

    // Stuck slave: ACCESS lasts exactly TIMEOUT cycles
    stall = 1'b1;
    set_req(1, 1'b1, 32'd9, 8'h5A, 1'b1);
    #1 chk("to_ready", 32'(req_ready), 32'd2);
    step();
    set_req(1, 1'b0, 32'd0, 8'h0, 1'b0);
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (penable) cycles++;
      else break;
    end
    chk("to_pen_cycles", 32'(cycles), 32'd16);
    chk("to_psel",  32'(psel), 32'd0);
    chk("to_rspv",  32'(rsp_valid), 32'd2);
    chk("to_err",   32'(rsp_err), 32'd1);
    chk("to_rdata", 32'(rsp_rdata), 32'd0);
    chk("to_evt",   32'(timeout_evt), 32'd1);
    step();
    chk("to_evt_drop", 32'(timeout_evt), 32'd0);
    stall = 1'b0;

    // Reset during ACCESS of a req0 read
    set_req(0, 1'b1, 32'd3, 8'h00, 1'b0);
    #1 chk("mr_ready", 32'(req_ready), 32'd1);
    step();
    set_req(0, 1'b0, 32'd0, 8'h0, 1'b0);
    step();
    chk("mr_in_access", 32'(penable), 32'd1);
    preset = 1'b1;
    step();
    chk("mr_psel", 32'(psel), 32'd0);
    chk("mr_pen",  32'(penable), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_rspv", 32'(rsp_valid), 32'd0);
    preset = 1'b0;
    step();
    chk("mr_rspv2", 32'(rsp_valid), 32'd0);
    // Pointer reset: requester 0 wins against requester 1
    set_req(0, 1'b1, 32'd3, 8'h00, 1'b0);
    set_req(1, 1'b1, 32'd6, 8'h00, 1'b0);
    #1 chk("mr_first_grant", 32'(req_ready), 32'd1);
    step();
    set_req(0, 1'b0, 32'd0, 8'h0, 1'b0);
    set_req(1, 1'b0, 32'd0, 8'h0, 1'b0);
    step();
    step();
    chk("mr_after_rspv",  32'(rsp_valid), 32'd1);
    chk("mr_after_rdata", 32'(rsp_rdata), 32'hA5);

    // req1 pulsed for one cycle while busy is withdrawn
    set_req(0, 1'b1, 32'd7, 8'h33, 1'b1);
    #1 chk("wd_ready0", 32'(req_ready), 32'd1);
    step();
    set_req(0, 1'b0, 32'd0, 8'h0, 1'b0);
    set_req(1, 1'b1, 32'd8, 8'h44, 1'b1);
    #1 chk("wd_ready_busy", 32'(req_ready), 32'd0);
    step();
    set_req(1, 1'b0, 32'd0, 8'h0, 1'b0);
    step();
    chk("wd_rspv0", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wd_no_rsp1", 32'(rsp_valid), 32'd0);
      chk("wd_idle",    32'(busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
